axi_mem_tester: RTL and testbench

Synthesizable AXI4 master that exercises the simulated DRAM model directly downstream of it. It writes a deterministic address-derived pattern across a configurable region in INCR bursts, reads the region back, and compares every beat. It reports done, an error count, and the first failing address. It connects port-for-port to the DRAM model's AXI slave interface and keeps one burst outstanding at a time.

---
 rtl/axi_mem_tester.sv | 215 +++++++++++++++++++++
 tb/tb_axi_mem_tester.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_tester.sv
// AXI4 memory tester: writes an address-derived pattern over a region in INCR
// bursts, reads it back, and counts mismatches and response errors.
module axi_mem_tester #(
  parameter int                    ADDR_BITS  = 32,
  parameter int                    DATA_BITS  = 64,
  parameter int                    ID_BITS    = 5,
  parameter int                    TXN_ID     = 0,
  parameter logic [ADDR_BITS-1:0]  BASE_ADDR  = '0,
  parameter int                    BURST_LEN  = 8,
  parameter int                    NUM_BURSTS = 16,
  parameter logic [31:0]           SEED       = 32'hA5A5_0000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    done,
  output logic                    busy,
  output logic [15:0]             err_count,
  output logic [ADDR_BITS-1:0]    first_err_addr,
  input  logic                    axi_aw_ready,
  output logic                    axi_aw_valid,
  output logic [ADDR_BITS-1:0]    axi_aw_bits_addr,
  output logic [7:0]              axi_aw_bits_len,
  output logic [2:0]              axi_aw_bits_size,
  output logic [1:0]              axi_aw_bits_burst,
  output logic                    axi_aw_bits_lock,
  output logic [3:0]              axi_aw_bits_cache,
  output logic [2:0]              axi_aw_bits_prot,
  output logic [3:0]              axi_aw_bits_qos,
  output logic [ID_BITS-1:0]      axi_aw_bits_id,
  input  logic                    axi_w_ready,
  output logic                    axi_w_valid,
  output logic [DATA_BITS-1:0]    axi_w_bits_data,
  output logic                    axi_w_bits_last,
  output logic [DATA_BITS/8-1:0]  axi_w_bits_strb,
  output logic                    axi_b_ready,
  input  logic                    axi_b_valid,
  input  logic [1:0]              axi_b_bits_resp,
  input  logic [ID_BITS-1:0]      axi_b_bits_id,
  input  logic                    axi_ar_ready,
  output logic                    axi_ar_valid,
  output logic [ADDR_BITS-1:0]    axi_ar_bits_addr,
  output logic [7:0]              axi_ar_bits_len,
  output logic [2:0]              axi_ar_bits_size,
  output logic [1:0]              axi_ar_bits_burst,
  output logic                    axi_ar_bits_lock,
  output logic [3:0]              axi_ar_bits_cache,
  output logic [2:0]              axi_ar_bits_prot,
  output logic [3:0]              axi_ar_bits_qos,
  output logic [ID_BITS-1:0]      axi_ar_bits_id,
  output logic                    axi_r_ready,
  input  logic                    axi_r_valid,
  input  logic [1:0]              axi_r_bits_resp,
  input  logic [DATA_BITS-1:0]    axi_r_bits_data,
  input  logic                    axi_r_bits_last,
  input  logic [ID_BITS-1:0]      axi_r_bits_id
);

  localparam int                   BYTES       = DATA_BITS / 8;
  localparam logic [2:0]           SIZE        = 3'($clog2(BYTES));
  localparam logic [7:0]           LEN         = 8'(BURST_LEN - 1);
  localparam logic [8:0]           BEAT_LAST   = 9'(BURST_LEN - 1);
  localparam logic [ADDR_BITS-1:0] BEAT_BYTES  = ADDR_BITS'(BYTES);
  localparam logic [ADDR_BITS-1:0] BURST_BYTES = ADDR_BITS'(BURST_LEN * BYTES);
  localparam logic [ID_BITS-1:0]   TXN         = ID_BITS'(TXN_ID);
  localparam int                   KW          = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam logic [KW-1:0]        K_LAST      = KW'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t                state, state_next;
  logic [KW-1:0]         k;
  logic [ADDR_BITS-1:0]  burst_addr;
  logic [ADDR_BITS-1:0]  beat_addr;
  logic [8:0]            beat;
  logic                  b_err, r_err;
  logic [ADDR_BITS-1:0]  err_addr;

  function automatic logic [DATA_BITS-1:0] pattern(input logic [ADDR_BITS-1:0] a);
    logic [31:0] w;
    w = 32'(a) ^ SEED;
    return {(DATA_BITS/32){w}};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    axi_aw_valid = 1'b0;
    axi_w_valid  = 1'b0;
    axi_b_ready  = 1'b0;
    axi_ar_valid = 1'b0;
    axi_r_ready  = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_AW;
      S_AW: begin
        axi_aw_valid = 1'b1;
        if (axi_aw_ready) state_next = S_W;
      end
      S_W: begin
        axi_w_valid = 1'b1;
        if (axi_w_ready && beat == BEAT_LAST) state_next = S_B;
      end
      S_B: begin
        axi_b_ready = 1'b1;
        if (axi_b_valid) state_next = (k == K_LAST) ? S_AR : S_AW;
      end
      S_AR: begin
        axi_ar_valid = 1'b1;
        if (axi_ar_ready) state_next = S_R;
      end
      S_R: begin
        axi_r_ready = 1'b1;
        if (axi_r_valid && axi_r_bits_last) state_next = (k == K_LAST) ? S_DONE : S_AR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Payloads are zero outside their channel's state so reset leaves every output at 0.
  assign axi_aw_bits_addr  = (state == S_AW) ? burst_addr : '0;
  assign axi_aw_bits_len   = (state == S_AW) ? LEN : 8'd0;
  assign axi_aw_bits_size  = (state == S_AW) ? SIZE : 3'd0;
  assign axi_aw_bits_burst = (state == S_AW) ? 2'b01 : 2'b00;
  assign axi_aw_bits_id    = (state == S_AW) ? TXN : '0;
  assign axi_aw_bits_lock  = 1'b0;
  assign axi_aw_bits_cache = 4'd0;
  assign axi_aw_bits_prot  = 3'd0;
  assign axi_aw_bits_qos   = 4'd0;

  assign axi_ar_bits_addr  = (state == S_AR) ? burst_addr : '0;
  assign axi_ar_bits_len   = (state == S_AR) ? LEN : 8'd0;
  assign axi_ar_bits_size  = (state == S_AR) ? SIZE : 3'd0;
  assign axi_ar_bits_burst = (state == S_AR) ? 2'b01 : 2'b00;
  assign axi_ar_bits_id    = (state == S_AR) ? TXN : '0;
  assign axi_ar_bits_lock  = 1'b0;
  assign axi_ar_bits_cache = 4'd0;
  assign axi_ar_bits_prot  = 3'd0;
  assign axi_ar_bits_qos   = 4'd0;

  assign axi_w_bits_data = (state == S_W) ? pattern(beat_addr) : '0;
  assign axi_w_bits_last = (state == S_W) && (beat == BEAT_LAST);
  assign axi_w_bits_strb = (state == S_W) ? '1 : '0;

  assign done = (state == S_DONE);
  assign busy = (state != S_IDLE) && (state != S_DONE);

  // Beats past the burst length are overrun beats and always count as errors.
  assign b_err = (state == S_B) && axi_b_valid &&
                 ((axi_b_bits_resp != 2'b00) || (axi_b_bits_id != TXN));
  assign r_err = (state == S_R) && axi_r_valid &&
                 ((axi_r_bits_data != pattern(beat_addr)) || (axi_r_bits_resp != 2'b00) ||
                  (axi_r_bits_id != TXN) || (axi_r_bits_last != (beat == BEAT_LAST)) ||
                  (beat > BEAT_LAST));
  assign err_addr = (state == S_B) ? burst_addr : beat_addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      k              <= '0;
      burst_addr     <= '0;
      beat_addr      <= '0;
      beat           <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          k              <= '0;
          burst_addr     <= BASE_ADDR;
          err_count      <= '0;
          first_err_addr <= '0;
        end
        S_AW, S_AR: if ((state == S_AW) ? axi_aw_ready : axi_ar_ready) begin
          beat      <= '0;
          beat_addr <= burst_addr;
        end
        S_W: if (axi_w_ready) begin
          if (beat != BEAT_LAST) beat <= beat + 9'd1;
          beat_addr <= beat_addr + BEAT_BYTES;
        end
        S_B: if (axi_b_valid) begin
          if (k == K_LAST) begin
            k          <= '0;
            burst_addr <= BASE_ADDR;
          end else begin
            k          <= k + KW'(1);
            burst_addr <= burst_addr + BURST_BYTES;
          end
        end
        S_R: if (axi_r_valid) begin
          if (!axi_r_bits_last) begin
            if (beat <= BEAT_LAST) beat <= beat + 9'd1;
            beat_addr <= beat_addr + BEAT_BYTES;
          end else if (k != K_LAST) begin
            k          <= k + KW'(1);
            burst_addr <= burst_addr + BURST_BYTES;
          end
        end
        default: ;
      endcase
      if (b_err || r_err) begin
        err_count <= sat_inc(err_count);
        if (err_count == 16'd0) first_err_addr <= err_addr;
      end
    end
  end

endmodule

// File: tb/tb_axi_mem_tester.sv
// Bench for axi_mem_tester: randomized AXI slave with a memory, fault knobs,
// and a region-level model of the expected error count and first error address.
module tb_axi_mem_tester;
  localparam int          AB = 32, DB = 64, IB = 5, BL = 4, NB = 2;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] SEED = 32'hA5A5_0000;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  always #5 clock = ~clock;

  logic done, busy;
  logic [15:0] err_count;
  logic [AB-1:0] first_err_addr;
  logic axi_aw_ready = 1'b0, axi_aw_valid;
  logic [AB-1:0] axi_aw_bits_addr;
  logic [7:0] axi_aw_bits_len;
  logic [2:0] axi_aw_bits_size, axi_aw_bits_prot;
  logic [1:0] axi_aw_bits_burst;
  logic axi_aw_bits_lock;
  logic [3:0] axi_aw_bits_cache, axi_aw_bits_qos;
  logic [IB-1:0] axi_aw_bits_id;
  logic axi_w_ready = 1'b0, axi_w_valid, axi_w_bits_last;
  logic [DB-1:0] axi_w_bits_data;
  logic [DB/8-1:0] axi_w_bits_strb;
  logic axi_b_ready, axi_b_valid = 1'b0;
  logic [1:0] axi_b_bits_resp = 2'b00;
  logic [IB-1:0] axi_b_bits_id = '0;
  logic axi_ar_ready = 1'b0, axi_ar_valid;
  logic [AB-1:0] axi_ar_bits_addr;
  logic [7:0] axi_ar_bits_len;
  logic [2:0] axi_ar_bits_size, axi_ar_bits_prot;
  logic [1:0] axi_ar_bits_burst;
  logic axi_ar_bits_lock;
  logic [3:0] axi_ar_bits_cache, axi_ar_bits_qos;
  logic [IB-1:0] axi_ar_bits_id;
  logic axi_r_ready, axi_r_valid = 1'b0, axi_r_bits_last = 1'b0;
  logic [1:0] axi_r_bits_resp = 2'b00;
  logic [DB-1:0] axi_r_bits_data = '0;
  logic [IB-1:0] axi_r_bits_id = '0;

  axi_mem_tester #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .ID_BITS(IB), .TXN_ID(0), .BASE_ADDR(BASE),
    .BURST_LEN(BL), .NUM_BURSTS(NB), .SEED(SEED)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .done(done), .busy(busy),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .axi_aw_ready(axi_aw_ready), .axi_aw_valid(axi_aw_valid), .axi_aw_bits_addr(axi_aw_bits_addr),
    .axi_aw_bits_len(axi_aw_bits_len), .axi_aw_bits_size(axi_aw_bits_size),
    .axi_aw_bits_burst(axi_aw_bits_burst), .axi_aw_bits_lock(axi_aw_bits_lock),
    .axi_aw_bits_cache(axi_aw_bits_cache), .axi_aw_bits_prot(axi_aw_bits_prot),
    .axi_aw_bits_qos(axi_aw_bits_qos), .axi_aw_bits_id(axi_aw_bits_id),
    .axi_w_ready(axi_w_ready), .axi_w_valid(axi_w_valid), .axi_w_bits_data(axi_w_bits_data),
    .axi_w_bits_last(axi_w_bits_last), .axi_w_bits_strb(axi_w_bits_strb),
    .axi_b_ready(axi_b_ready), .axi_b_valid(axi_b_valid), .axi_b_bits_resp(axi_b_bits_resp),
    .axi_b_bits_id(axi_b_bits_id),
    .axi_ar_ready(axi_ar_ready), .axi_ar_valid(axi_ar_valid), .axi_ar_bits_addr(axi_ar_bits_addr),
    .axi_ar_bits_len(axi_ar_bits_len), .axi_ar_bits_size(axi_ar_bits_size),
    .axi_ar_bits_burst(axi_ar_bits_burst), .axi_ar_bits_lock(axi_ar_bits_lock),
    .axi_ar_bits_cache(axi_ar_bits_cache), .axi_ar_bits_prot(axi_ar_bits_prot),
    .axi_ar_bits_qos(axi_ar_bits_qos), .axi_ar_bits_id(axi_ar_bits_id),
    .axi_r_ready(axi_r_ready), .axi_r_valid(axi_r_valid), .axi_r_bits_resp(axi_r_bits_resp),
    .axi_r_bits_data(axi_r_bits_data), .axi_r_bits_last(axi_r_bits_last),
    .axi_r_bits_id(axi_r_bits_id)
  );

  int checks = 0, errors = 0;

  // Slave behaviour knobs (-1 disables a fault)
  int pct_rdy = 100, pct_vld = 100;
  int k_berr = -1, k_corr_burst = -1, k_corr_beat = -1, k_early_burst = -1, k_early_beat = -1;
  bit k_rresp = 1'b0;
  int clr_seq = 0, clr_seen = 0;

  int aw_count, w_count, b_count, ar_count, r_count, aw_bad, w_bad, ar_bad, stable_bad;
  logic [63:0] first_w_data;
  logic [63:0] mem [logic [31:0]];
  bit b_pending, r_active, b_fire, r_fire, aw_hold, w_hold, ar_hold;
  int w_beat, r_beat, r_idx;
  logic [31:0] w_base, r_base, aw_prev, ar_prev;
  logic [64:0] w_prev;

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {2{a ^ SEED}};
  endfunction

  function automatic bit chance(input int pct);
    return int'($urandom_range(99, 0)) < pct;
  endfunction

  // Expected outcome of one pass over the whole region given the fault knobs.
  function automatic void model(output int cnt, output logic [31:0] first, output int rbeats);
    logic [31:0] a;
    bit bad, el;
    cnt = 0; first = '0; rbeats = 0;
    for (int b = 0; b < NB; b++)
      if (k_berr == b) begin
        if (cnt == 0) first = BASE + 32'(b * BL * 8);
        cnt++;
      end
    for (int b = 0; b < NB; b++)
      for (int j = 0; j < BL; j++) begin
        a = BASE + 32'((b * BL + j) * 8);
        el = (k_early_burst == b) && (k_early_beat == j);
        bad = k_rresp || ((k_corr_burst == b) && (k_corr_beat == j)) || (el && j != BL - 1);
        rbeats++;
        if (bad) begin
          if (cnt == 0) first = a;
          cnt++;
        end
        if (el) break;
      end
  endfunction

  // Slave: decides ready/valid at each falling edge; handshakes land on the next rising edge.
  always @(negedge clock) begin
    logic [31:0] a, ea;
    bit rf;
    if (clr_seq != clr_seen) begin
      clr_seen = clr_seq;
      aw_count = 0; w_count = 0; b_count = 0; ar_count = 0; r_count = 0;
      aw_bad = 0; w_bad = 0; ar_bad = 0; stable_bad = 0; first_w_data = '0;
    end
    if (reset) begin
      axi_aw_ready = 0; axi_w_ready = 0; axi_ar_ready = 0; axi_b_valid = 0; axi_r_valid = 0;
      b_pending = 0; r_active = 0; b_fire = 0; r_fire = 0; aw_hold = 0; w_hold = 0; ar_hold = 0;
    end else begin
      rf = r_fire;
      if (b_fire) begin b_pending = 0; b_count++; end
      if (r_fire) begin
        r_count++;
        if (axi_r_bits_last) r_active = 0;
        else r_beat++;
      end
      if (aw_hold && (!axi_aw_valid || axi_aw_bits_addr != aw_prev)) stable_bad++;
      if (w_hold && (!axi_w_valid || {axi_w_bits_data, axi_w_bits_last} != w_prev)) stable_bad++;
      if (ar_hold && (!axi_ar_valid || axi_ar_bits_addr != ar_prev)) stable_bad++;

      axi_aw_ready = chance(pct_rdy);
      axi_w_ready  = chance(pct_rdy);
      axi_ar_ready = chance(pct_rdy);
      if (!b_pending) axi_b_valid = 0;
      else if (!axi_b_valid) begin
        axi_b_valid = chance(pct_vld);
        axi_b_bits_resp = (k_berr == b_count) ? 2'b10 : 2'b00;
        axi_b_bits_id = '0;
      end
      if (!r_active) axi_r_valid = 0;
      else if (!axi_r_valid || rf) begin
        axi_r_valid = chance(pct_vld);
        a = r_base + 32'(r_beat * 8);
        axi_r_bits_data = mem.exists(a) ? mem[a] : pat(a);
        if (k_corr_burst == r_idx && k_corr_beat == r_beat) axi_r_bits_data ^= 64'h1;
        axi_r_bits_resp = k_rresp ? 2'b10 : 2'b00;
        axi_r_bits_last = (r_beat == BL - 1) || (k_early_burst == r_idx && k_early_beat == r_beat);
        axi_r_bits_id = '0;
      end

      aw_hold = axi_aw_valid && !axi_aw_ready; aw_prev = axi_aw_bits_addr;
      w_hold  = axi_w_valid && !axi_w_ready;   w_prev = {axi_w_bits_data, axi_w_bits_last};
      ar_hold = axi_ar_valid && !axi_ar_ready; ar_prev = axi_ar_bits_addr;
      if (axi_aw_valid && axi_aw_ready) begin
        ea = BASE + 32'((aw_count % NB) * BL * 8);
        if (axi_aw_bits_addr != ea || axi_aw_bits_len != 8'(BL - 1) || axi_aw_bits_size != 3'd3 ||
            axi_aw_bits_burst != 2'b01 || axi_aw_bits_id != '0 || axi_aw_bits_lock != 1'b0 ||
            axi_aw_bits_cache != 4'd0 || axi_aw_bits_prot != 3'd0 || axi_aw_bits_qos != 4'd0)
          aw_bad++;
        aw_count++; w_base = axi_aw_bits_addr; w_beat = 0;
      end
      if (axi_w_valid && axi_w_ready) begin
        a  = w_base + 32'(w_beat * 8);
        ea = BASE + 32'((w_count % (NB * BL)) * 8);
        if (a != ea || axi_w_bits_data != pat(ea) || axi_w_bits_last != (w_beat == BL - 1) ||
            axi_w_bits_strb != 8'hFF)
          w_bad++;
        if (w_count == 0) first_w_data = axi_w_bits_data;
        mem[a] = axi_w_bits_data;
        w_count++; w_beat++;
        if (axi_w_bits_last) b_pending = 1;
      end
      if (axi_ar_valid && axi_ar_ready) begin
        ea = BASE + 32'((ar_count % NB) * BL * 8);
        if (axi_ar_bits_addr != ea || axi_ar_bits_len != 8'(BL - 1) || axi_ar_bits_size != 3'd3 ||
            axi_ar_bits_burst != 2'b01 || axi_ar_bits_id != '0)
          ar_bad++;
        r_active = 1; r_base = axi_ar_bits_addr; r_beat = 0; r_idx = ar_count; ar_count++;
      end
      b_fire = axi_b_valid && axi_b_ready;
      r_fire = axi_r_valid && axi_r_ready;
    end
  end

  task automatic setup(input int rdy, input int vld, input int berr, input int cb, input int cj,
                       input int eb, input int ej, input bit rresp);
    pct_rdy = rdy; pct_vld = vld; k_berr = berr; k_corr_burst = cb; k_corr_beat = cj;
    k_early_burst = eb; k_early_beat = ej; k_rresp = rresp;
    clr_seq++;
    repeat (2) @(negedge clock);
  endtask

  task automatic start_pass();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, axi_aw_valid, axi_w_valid, axi_b_ready, axi_ar_valid, axi_r_ready} !== 7'd0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000000",
        {busy, done, axi_aw_valid, axi_w_valid, axi_b_ready, axi_ar_valid, axi_r_ready});
    end
    checks++;
    if ({err_count, first_err_addr} !== 48'd0) begin
      errors++; $display("FAIL reset_status: got %0h/%0h want 0/0", err_count, first_err_addr);
    end
    checks++;
    if ({axi_aw_bits_addr, axi_aw_bits_len, axi_aw_bits_size, axi_aw_bits_burst, axi_w_bits_data,
         axi_w_bits_last, axi_w_bits_strb, axi_ar_bits_addr} !== '0) begin
      errors++; $display("FAIL reset_payload: got aw %0h w %0h ar %0h want all zero",
        axi_aw_bits_addr, axi_w_bits_data, axi_ar_bits_addr);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_ideal();
    int ecnt, rb; logic [31:0] efirst; bit ok; logic [63:0] exp0;
    setup(100, 100, -1, -1, -1, -1, -1, 1'b0);
    model(ecnt, efirst, rb);
    start_pass();
    checks++;
    if ({axi_aw_valid, busy} !== 2'b11) begin
      errors++; $display("FAIL start_latency: got aw_valid %b busy %b want 1 1", axi_aw_valid, busy);
    end
    wait_done(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ideal_done: got timeout want done"); end
    checks++;
    if ({aw_count, w_count, b_count, ar_count, r_count} !== {NB, NB * BL, NB, NB, rb}) begin
      errors++; $display("FAIL ideal_counts: got aw%0d w%0d b%0d ar%0d r%0d want %0d %0d %0d %0d %0d",
        aw_count, w_count, b_count, ar_count, r_count, NB, NB * BL, NB, NB, rb);
    end
    checks++;
    if ({aw_bad, w_bad, ar_bad} !== 96'd0) begin
      errors++; $display("FAIL ideal_payload: got bad aw%0d w%0d ar%0d want 0", aw_bad, w_bad, ar_bad);
    end
    exp0 = {2{BASE ^ SEED}};
    checks++;
    if (first_w_data !== exp0) begin
      errors++; $display("FAIL beat0_data: got %h want %h", first_w_data, exp0);
    end
    checks++;
    if ({done, busy, err_count, first_err_addr} !== {1'b1, 1'b0, 16'(ecnt), efirst}) begin
      errors++; $display("FAIL ideal_status: got done%b busy%b err%0d addr%0h want 1 0 %0d %0h",
        done, busy, err_count, first_err_addr, ecnt, efirst);
    end
  endtask

  task automatic test_fault(input string name, input int berr, input int cb, input int cj,
                            input int eb, input int ej, input bit rresp);
    int ecnt, rb; logic [31:0] efirst; bit ok;
    setup(100, 100, berr, cb, cj, eb, ej, rresp);
    model(ecnt, efirst, rb);
    start_pass();
    wait_done(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_done: got timeout want done", name); end
    checks++;
    if (err_count !== 16'(ecnt)) begin
      errors++; $display("FAIL %s_err_count: got %0d want %0d", name, err_count, ecnt);
    end
    checks++;
    if (first_err_addr !== efirst) begin
      errors++; $display("FAIL %s_first_addr: got %0h want %0h", name, first_err_addr, efirst);
    end
    checks++;
    if ({ar_count, r_count} !== {NB, rb}) begin
      errors++; $display("FAIL %s_reads: got ar%0d r%0d want %0d %0d", name, ar_count, r_count, NB, rb);
    end
  endtask

  task automatic test_backpressure();
    int ecnt, rb; logic [31:0] efirst; bit ok;
    for (int it = 0; it < 3; it++) begin
      setup(40 + 20 * it, 40 + 20 * it, -1, -1, -1, -1, -1, 1'b0);
      model(ecnt, efirst, rb);
      start_pass();
      wait_done(5000, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bp%0d_done: got timeout want done", it); end
      checks++;
      if ({stable_bad, aw_bad, w_bad, ar_bad} !== 128'd0) begin
        errors++; $display("FAIL bp%0d_stable: got stable%0d aw%0d w%0d ar%0d want 0",
          it, stable_bad, aw_bad, w_bad, ar_bad);
      end
      checks++;
      if ({w_count, r_count, err_count} !== {NB * BL, rb, 16'(ecnt)}) begin
        errors++; $display("FAIL bp%0d_result: got w%0d r%0d err%0d want %0d %0d %0d",
          it, w_count, r_count, err_count, NB * BL, rb, ecnt);
      end
    end
  endtask

  task automatic test_reset_mid_w();
    bit ok, seen;
    setup(100, 100, -1, 1, 0, -1, -1, 1'b0);
    start_pass();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (axi_w_valid) begin seen = 1'b1; break; end
      @(negedge clock);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midw_reach: got no W beat want W beat"); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({busy, done, axi_aw_valid, axi_w_valid, axi_b_ready, axi_ar_valid, axi_r_ready,
         axi_w_bits_last, err_count, first_err_addr, axi_w_bits_data} !== '0) begin
      errors++; $display("FAIL midw_reset: got busy%b wv%b err%0d data%0h want all zero",
        busy, axi_w_valid, err_count, axi_w_bits_data);
    end
    reset = 1'b0;
    setup(100, 100, -1, -1, -1, -1, -1, 1'b0);
    start_pass();
    repeat (3) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(2000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midw_done: got timeout want done"); end
    checks++;
    if ({aw_count, w_count, ar_count, err_count} !== {NB, NB * BL, NB, 16'd0}) begin
      errors++; $display("FAIL midw_pass: got aw%0d w%0d ar%0d err%0d want %0d %0d %0d 0",
        aw_count, w_count, ar_count, err_count, NB, NB * BL, NB);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ideal();
    test_fault("corrupt", -1, 1, 2, -1, -1, 1'b0);
    test_fault("resp", 0, -1, -1, -1, -1, 1'b1);
    test_fault("early_last", -1, -1, -1, 0, 1, 1'b0);
    test_backpressure();
    test_reset_mid_w();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
